// File: rtl/floppy_ram_arbiter.sv
// floppy_ram_arbiter
// Shares one single-port track-image RAM between the Disk II nibble stream
// and the host loader/flusher. Each access takes three cycles:
// IDLE (arbitrate), ACCESS (drive the RAM) and DONE (acknowledge).
// Floppy writes honour per-drive write protection, and every completed,
// unprotected floppy write marks its drive's image dirty.
module floppy_ram_arbiter #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 8
) (
    input  logic              PH_2,
    input  logic              RESET_N,
    // floppy requester
    input  logic              FLOP_REQ,
    input  logic              FLOP_WE,
    input  logic              FLOP_DRIVE,
    input  logic [ADDR_W-1:0] FLOP_ADDR,
    input  logic [DATA_W-1:0] FLOP_WDATA,
    output logic              FLOP_ACK,
    output logic [DATA_W-1:0] FLOP_RDATA,
    // host requester
    input  logic              HOST_REQ,
    input  logic              HOST_WE,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    input  logic [DATA_W-1:0] HOST_WDATA,
    output logic              HOST_ACK,
    output logic [DATA_W-1:0] HOST_RDATA,
    // protection and dirty tracking
    input  logic [1:0]        WP,
    input  logic [1:0]        DIRTY_CLR,
    output logic [1:0]        DIRTY,
    output logic              WP_HIT,
    // RAM port
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [DATA_W-1:0] RAM_WDATA,
    input  logic [DATA_W-1:0] RAM_RDATA
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic grant_flop;
    logic grant_host;

    // grant latch: who owns the access in flight and what it asked for.
    // RAM_ADDR / RAM_WDATA double as the address and data latch.
    logic host_p0;
    logic we_p0;
    logic drive_p0;

    // suppression decision taken at the close of ACCESS, reported in DONE
    logic supp_p1;

    // 1 = host was served last, so the floppy wins the next tie
    logic last_host;

    logic       wp_block;
    logic [1:0] dirty_set;

    // Arbitration and next-state selection
    always_comb begin
        state_nxt  = state;
        grant_flop = 1'b0;
        grant_host = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FLOP_REQ && HOST_REQ) begin
                    if (last_host) begin
                        grant_flop = 1'b1;
                    end else begin
                        grant_host = 1'b1;
                    end
                end else if (FLOP_REQ) begin
                    grant_flop = 1'b1;
                end else if (HOST_REQ) begin
                    grant_host = 1'b1;
                end
                if (grant_flop || grant_host) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Strobes derived from the state; all fall at once when reset forces IDLE
    always_comb begin
        wp_block  = !host_p0 && we_p0 && WP[drive_p0];
        RAM_WE    = (state == ST_ACCESS) && we_p0 && !wp_block;
        FLOP_ACK  = (state == ST_DONE) && !host_p0;
        HOST_ACK  = (state == ST_DONE) && host_p0;
        WP_HIT    = (state == ST_DONE) && !host_p0 && supp_p1;
        dirty_set = 2'b00;
        if ((state == ST_DONE) && !host_p0 && we_p0 && !supp_p1) begin
            dirty_set[drive_p0] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the winning request; later changes on its inputs are ignored
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            host_p0   <= 1'b0;
            we_p0     <= 1'b0;
            drive_p0  <= 1'b0;
            RAM_ADDR  <= '0;
            RAM_WDATA <= '0;
        end else if (grant_flop) begin
            host_p0   <= 1'b0;
            we_p0     <= FLOP_WE;
            drive_p0  <= FLOP_DRIVE;
            RAM_ADDR  <= FLOP_ADDR;
            RAM_WDATA <= FLOP_WDATA;
        end else if (grant_host) begin
            host_p0   <= 1'b1;
            we_p0     <= HOST_WE;
            drive_p0  <= 1'b0;
            RAM_ADDR  <= HOST_ADDR;
            RAM_WDATA <= HOST_WDATA;
        end
    end

    // Remember whether the write just presented was blocked, for WP_HIT and DIRTY
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            supp_p1 <= 1'b0;
        end else if (state == ST_ACCESS) begin
            supp_p1 <= wp_block;
        end
    end

    // RAM data is valid by the close of ACCESS, so it lands together with ACK
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            FLOP_RDATA <= '0;
            HOST_RDATA <= '0;
        end else if ((state == ST_ACCESS) && !we_p0) begin
            if (host_p0) begin
                HOST_RDATA <= RAM_RDATA;
            end else begin
                FLOP_RDATA <= RAM_RDATA;
            end
        end
    end

    // Fairness: record who was served once the access completes
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            last_host <= 1'b1;
        end else if (state == ST_DONE) begin
            last_host <= host_p0;
        end
    end

    // Dirty flags: a set in DONE overrides a simultaneous clear strobe
    always_ff @(posedge PH_2 or negedge RESET_N) begin
        if (!RESET_N) begin
            DIRTY <= 2'b00;
        end else begin
            DIRTY <= (DIRTY & ~DIRTY_CLR) | dirty_set;
        end
    end

endmodule

// File: tb/tb_floppy_ram_arbiter.sv
// Testbench for floppy_ram_arbiter: a transaction-level model predicts every
// output each cycle; directed tests add literal expectations.
module tb_floppy_ram_arbiter;

    logic        PH_2;
    logic        RESET_N;
    logic        FLOP_REQ, FLOP_WE, FLOP_DRIVE;
    logic [17:0] FLOP_ADDR;
    logic [7:0]  FLOP_WDATA;
    logic        FLOP_ACK;
    logic [7:0]  FLOP_RDATA;
    logic        HOST_REQ, HOST_WE;
    logic [17:0] HOST_ADDR;
    logic [7:0]  HOST_WDATA;
    logic        HOST_ACK;
    logic [7:0]  HOST_RDATA;
    logic [1:0]  WP, DIRTY_CLR, DIRTY;
    logic        WP_HIT;
    logic [17:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  RAM_RDATA;

    int checks   = 0;
    int failures = 0;

    floppy_ram_arbiter #(.ADDR_W(18), .DATA_W(8)) dut (
        .PH_2(PH_2), .RESET_N(RESET_N),
        .FLOP_REQ(FLOP_REQ), .FLOP_WE(FLOP_WE), .FLOP_DRIVE(FLOP_DRIVE),
        .FLOP_ADDR(FLOP_ADDR), .FLOP_WDATA(FLOP_WDATA),
        .FLOP_ACK(FLOP_ACK), .FLOP_RDATA(FLOP_RDATA),
        .HOST_REQ(HOST_REQ), .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR),
        .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK), .HOST_RDATA(HOST_RDATA),
        .WP(WP), .DIRTY_CLR(DIRTY_CLR), .DIRTY(DIRTY), .WP_HIT(WP_HIT),
        .RAM_ADDR(RAM_ADDR), .RAM_WE(RAM_WE), .RAM_WDATA(RAM_WDATA),
        .RAM_RDATA(RAM_RDATA)
    );

    initial PH_2 = 1'b0;
    always #5 PH_2 = ~PH_2;

    // external RAM: read data follows the address, writes land mid-cycle
    logic [7:0] ram [0:262143];
    assign RAM_RDATA = ram[RAM_ADDR];
    always @(negedge PH_2) begin
        if (RAM_WE) ram[RAM_ADDR] = RAM_WDATA;
    end

    // ---------------- reference model ----------------
    // An access is a transaction: granted at an edge, RAM busy for the next
    // cycle, acknowledged the cycle after, then one idle cycle before the
    // next grant can be taken.
    logic [7:0]  mdl_mem [0:262143];
    int          m_slot = 0;        // cycles since grant (0 = none in flight)
    logic        m_last_host = 1'b1;
    logic [1:0]  m_dirty = 2'b00;
    logic [1:0]  m_set;
    logic [7:0]  m_frd = 8'h00, m_hrd = 8'h00;
    logic [17:0] m_addr = '0;
    logic [7:0]  m_wdata = 8'h00;
    logic        m_host = 1'b0, m_we = 1'b0, m_drv = 1'b0, m_supp = 1'b0;

    always @(posedge PH_2) begin
        if (!RESET_N) begin
            m_slot = 0; m_last_host = 1'b1; m_dirty = 2'b00;
            m_frd = 8'h00; m_hrd = 8'h00; m_addr = '0; m_wdata = 8'h00;
            m_host = 1'b0; m_we = 1'b0; m_drv = 1'b0; m_supp = 1'b0;
        end else begin
            m_set = 2'b00;
            if (m_slot == 2) begin
                if (!m_host && m_we && !m_supp) m_set[m_drv] = 1'b1;
                m_last_host = m_host;
            end
            m_dirty = (m_dirty & ~DIRTY_CLR) | m_set;
            if (m_slot == 1) begin
                m_supp = !m_host && m_we && WP[m_drv];
                if (m_we) begin
                    if (!m_supp) mdl_mem[m_addr] = m_wdata;
                end else if (m_host) begin
                    m_hrd = mdl_mem[m_addr];
                end else begin
                    m_frd = mdl_mem[m_addr];
                end
                m_slot = 2;
            end else if (m_slot == 2) begin
                m_slot = 0;
            end else if (FLOP_REQ && (!HOST_REQ || m_last_host)) begin
                m_host = 1'b0; m_we = FLOP_WE; m_drv = FLOP_DRIVE;
                m_addr = FLOP_ADDR; m_wdata = FLOP_WDATA; m_slot = 1;
            end else if (HOST_REQ) begin
                m_host = 1'b1; m_we = HOST_WE; m_drv = 1'b0;
                m_addr = HOST_ADDR; m_wdata = HOST_WDATA; m_slot = 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model, mid-cycle
    logic e_we, e_fack, e_hack, e_hit;
    always @(negedge PH_2) begin
        if (!RESET_N) begin
            chk("rst_ram_we", 32'(RAM_WE), 32'd0);
            chk("rst_flop_ack", 32'(FLOP_ACK), 32'd0);
            chk("rst_host_ack", 32'(HOST_ACK), 32'd0);
            chk("rst_wp_hit", 32'(WP_HIT), 32'd0);
            chk("rst_ram_addr", 32'(RAM_ADDR), 32'd0);
            chk("rst_ram_wdata", 32'(RAM_WDATA), 32'd0);
            chk("rst_flop_rdata", 32'(FLOP_RDATA), 32'd0);
            chk("rst_host_rdata", 32'(HOST_RDATA), 32'd0);
            chk("rst_dirty", 32'(DIRTY), 32'd0);
        end else begin
            e_we   = (m_slot == 1) && m_we && !(!m_host && WP[m_drv]);
            e_fack = (m_slot == 2) && !m_host;
            e_hack = (m_slot == 2) && m_host;
            e_hit  = e_fack && m_supp;
            chk("ram_we", 32'(RAM_WE), 32'(e_we));
            chk("flop_ack", 32'(FLOP_ACK), 32'(e_fack));
            chk("host_ack", 32'(HOST_ACK), 32'(e_hack));
            chk("wp_hit", 32'(WP_HIT), 32'(e_hit));
            chk("ram_addr", 32'(RAM_ADDR), 32'(m_addr));
            chk("ram_wdata", 32'(RAM_WDATA), 32'(m_wdata));
            chk("flop_rdata", 32'(FLOP_RDATA), 32'(m_frd));
            chk("host_rdata", 32'(HOST_RDATA), 32'(m_hrd));
            chk("dirty", 32'(DIRTY), 32'(m_dirty));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge PH_2);
        #2;
    endtask

    task automatic do_reset;
        RESET_N = 1'b0;
        tick; tick;
        RESET_N = 1'b1;
    endtask

    // one request from issue to drop; reports latency, RAM_WE cycles and WP_HIT
    task automatic run_req(input bit host, input bit we, input bit drv,
                           input logic [17:0] addr, input logic [7:0] wd,
                           input logic [1:0] clr_at_ack, input bit scramble,
                           output int lat, output int we_cnt, output bit hit);
        bit done;
        done = 1'b0; lat = 0; we_cnt = 0; hit = 1'b0;
        if (host) begin
            HOST_REQ = 1'b1; HOST_WE = we; HOST_ADDR = addr; HOST_WDATA = wd;
        end else begin
            FLOP_REQ = 1'b1; FLOP_WE = we; FLOP_DRIVE = drv;
            FLOP_ADDR = addr; FLOP_WDATA = wd;
        end
        for (int i = 0; i < 20 && !done; i++) begin
            tick;
            lat++;
            #1;
            if (RAM_WE) we_cnt++;
            if (host ? HOST_ACK : FLOP_ACK) begin
                done = 1'b1;
                hit  = WP_HIT;
            end
            if (scramble && !host && i == 0) begin
                FLOP_ADDR = ~addr; FLOP_WE = ~we; FLOP_WDATA = ~wd;
            end
        end
        chk("req_ack_seen", 32'(done), 32'd1);
        HOST_REQ = 1'b0;
        FLOP_REQ = 1'b0;
        DIRTY_CLR = clr_at_ack;
        tick;
        DIRTY_CLR = 2'b00;
    endtask

    // both requesters raise together; floppy expected first, host 3 cycles later
    task automatic tie_pair(input int n);
        int tf, th;
        tf = -1; th = -1;
        FLOP_REQ = 1'b1; FLOP_WE = 1'b0; FLOP_ADDR = 18'h00301;
        HOST_REQ = 1'b1; HOST_WE = 1'b0; HOST_ADDR = 18'h00300 + 18'(n);
        for (int i = 0; i < 30 && (tf < 0 || th < 0); i++) begin
            tick;
            #1;
            if (FLOP_ACK && tf < 0) begin tf = i; FLOP_REQ = 1'b0; end
            if (HOST_ACK && th < 0) begin th = i; HOST_REQ = 1'b0; end
        end
        chk("tie_flop_ack_cycle", 32'(tf), 32'd1);
        chk("tie_host_gap", 32'(th - tf), 32'd3);
        FLOP_REQ = 1'b0; HOST_REQ = 1'b0;
        tick;
    endtask

    int lat, wec;
    bit hit;

    initial begin
        for (int i = 0; i < 262144; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            mdl_mem[i] = 8'(i * 7 + 3);
        end
        ram[18'h00123]     = 8'hD5;
        mdl_mem[18'h00123] = 8'hD5;
        RESET_N = 1'b0;
        FLOP_REQ = 1'b0; FLOP_WE = 1'b0; FLOP_DRIVE = 1'b0;
        FLOP_ADDR = '0; FLOP_WDATA = '0;
        HOST_REQ = 1'b0; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
        WP = 2'b00; DIRTY_CLR = 2'b00;
        do_reset;

        // floppy read only
        run_req(1'b0, 1'b0, 1'b0, 18'h00123, 8'h00, 2'b00, 1'b0, lat, wec, hit);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_flop_rdata", 32'(FLOP_RDATA), 32'hD5);
        chk("rd_ram_addr_held", 32'(RAM_ADDR), 32'h00123);
        chk("rd_host_rdata", 32'(HOST_RDATA), 32'h00);

        // contention from reset, then 7 further ties
        do_reset;
        for (int n = 0; n < 8; n++) tie_pair(n);

        // write protect on drive 1
        WP = 2'b01;
        run_req(1'b0, 1'b1, 1'b0, 18'h00040, 8'hAA, 2'b00, 1'b0, lat, wec, hit);
        chk("wp_ram_we_cycles", 32'(wec), 32'd0);
        chk("wp_hit", 32'(hit), 32'd1);
        chk("wp_dirty", 32'(DIRTY), 32'd0);
        // unprotected; request inputs scrambled after grant
        WP = 2'b00;
        run_req(1'b0, 1'b1, 1'b0, 18'h00040, 8'hAA, 2'b00, 1'b1, lat, wec, hit);
        chk("wr_ram_we_cycles", 32'(wec), 32'd1);
        chk("wr_hit", 32'(hit), 32'd0);
        chk("wr_dirty", 32'(DIRTY), 32'h1);
        run_req(1'b0, 1'b0, 1'b0, 18'h00040, 8'h00, 2'b00, 1'b0, lat, wec, hit);
        chk("wr_readback", 32'(FLOP_RDATA), 32'hAA);

        // dirty set/clear collision on drive 2
        DIRTY_CLR = 2'b11; tick; DIRTY_CLR = 2'b00;
        chk("clr_all", 32'(DIRTY), 32'd0);
        run_req(1'b0, 1'b1, 1'b1, 18'h00041, 8'h33, 2'b10, 1'b0, lat, wec, hit);
        chk("collide_set_wins", 32'(DIRTY), 32'h2);
        DIRTY_CLR = 2'b10; tick; DIRTY_CLR = 2'b00;
        chk("clr_drive2", 32'(DIRTY), 32'd0);

        // host write (ignores WP, leaves DIRTY) then floppy read
        run_req(1'b0, 1'b1, 1'b1, 18'h00043, 8'h11, 2'b00, 1'b0, lat, wec, hit);
        chk("pre_host_dirty", 32'(DIRTY), 32'h2);
        WP = 2'b11;
        run_req(1'b1, 1'b1, 1'b0, 18'h018A7, 8'h96, 2'b00, 1'b0, lat, wec, hit);
        chk("host_wr_we_cycles", 32'(wec), 32'd1);
        chk("host_wr_dirty", 32'(DIRTY), 32'h2);
        run_req(1'b0, 1'b0, 1'b0, 18'h018A7, 8'h00, 2'b00, 1'b0, lat, wec, hit);
        chk("host_wr_readback", 32'(FLOP_RDATA), 32'h96);

        // reset during ACCESS of a floppy write
        WP = 2'b00;
        FLOP_REQ = 1'b1; FLOP_WE = 1'b1; FLOP_DRIVE = 1'b0;
        FLOP_ADDR = 18'h00200; FLOP_WDATA = 8'h5A;
        tick;
        #1;
        chk("mid_ram_we_before", 32'(RAM_WE), 32'd1);
        RESET_N = 1'b0;
        #1;
        chk("mid_ram_we_async", 32'(RAM_WE), 32'd0);
        chk("mid_flop_ack", 32'(FLOP_ACK), 32'd0);
        chk("mid_ram_addr", 32'(RAM_ADDR), 32'd0);
        chk("mid_dirty", 32'(DIRTY), 32'd0);
        FLOP_REQ = 1'b0;
        tick; tick;
        RESET_N = 1'b1;
        tick;
        chk("post_rst_dirty", 32'(DIRTY), 32'd0);
        run_req(1'b0, 1'b0, 1'b0, 18'h00200, 8'h00, 2'b00, 1'b0, lat, wec, hit);
        chk("post_rst_latency", 32'(lat), 32'd2);
        chk("post_rst_unwritten", 32'(FLOP_RDATA), 32'h03);

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/floppy_ram_arbiter.md
# floppy_ram_arbiter

Single-port arbiter and sequencer for the shared floppy track-image RAM. It multiplexes the Disk II nibble stream, running at the CPU rate, with a host loader/flusher that moves track images between the RAM and SD storage. It enforces per-drive write protection on floppy writes and keeps per-drive dirty flags that tell the host which images need flushing. It sits between the floppy emulation (18-bit FLOPPY_ADDRESS space) and the external RAM port.

## Interface
Parameters:
- ADDR_W, 18, RAM byte-address width; matches the floppy address space.
- DATA_W, 8, RAM data width.

Ports:
- PH_2  in  1  clock; all state changes on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- FLOP_REQ  in  1  floppy access request; level, held until FLOP_ACK.
- FLOP_WE  in  1  1 = write, 0 = read; sampled at grant.
- FLOP_DRIVE  in  1  0 = drive 1, 1 = drive 2; sampled at grant.
- FLOP_ADDR  in  ADDR_W  floppy byte address.
- FLOP_WDATA  in  DATA_W  floppy write byte.
- FLOP_ACK  out  1  one-cycle completion pulse.
- FLOP_RDATA  out  DATA_W  read byte; held until the next floppy read completes.
- HOST_REQ, HOST_WE, HOST_ADDR, HOST_WDATA  in  1/1/ADDR_W/DATA_W  host request; same rules as floppy.
- HOST_ACK  out  1  one-cycle completion pulse.
- HOST_RDATA  out  DATA_W  host read byte; held.
- WP  in  2  write-protect, bit0 = drive 1, bit1 = drive 2.
- DIRTY_CLR  in  2  one-cycle clear strobes for DIRTY.
- DIRTY  out  2  per-drive "image modified since last clear".
- WP_HIT  out  1  one-cycle pulse coincident with FLOP_ACK when a protected write was suppressed.
- RAM_ADDR  out  ADDR_W  RAM address.
- RAM_WE  out  1  RAM write strobe.
- RAM_WDATA  out  DATA_W  RAM write data.
- RAM_RDATA  in  DATA_W  RAM read data; valid one cycle after the address is presented.

## Operation
- Three-state FSM:
  - IDLE: arbitrate.
  - ACCESS: RAM pins driven from the latched grant.
  - DONE: capture read data, pulse ACK, then return to IDLE.
- IDLE arbitration:
  - If only one requester has REQ=1, grant it.
  - If both have REQ=1, grant the one not served last (LAST register).
  - LAST resets to "host", so the floppy wins the first tie.
  - On grant, latch the requester's address, WE, wdata and (for floppy) drive, and enter ACCESS.
- ACCESS:
  - RAM_ADDR and RAM_WDATA come from the latch.
  - RAM_WE = latched WE, except it is 0 for a floppy write when WP[drive]=1.
  - Next state is DONE.
- DONE:
  - For reads, register RAM_RDATA into the granted requester's RDATA.
  - Pulse that requester's ACK.
  - For a suppressed floppy write, also pulse WP_HIT.
  - Update LAST; next state is IDLE.
- Requesters must drop REQ in the cycle after ACK. A REQ still high in IDLE is treated as a new request.
- DIRTY[d]:
  - Set in DONE of a completed, unsuppressed floppy write to drive d.
  - Cleared by DIRTY_CLR[d].
  - If set and clear happen in the same cycle, set wins.
  - Host writes never touch DIRTY.
- Host writes ignore WP.
- Outside ACCESS: RAM_WE=0, and RAM_ADDR/RAM_WDATA hold their last value.

## Timing
- Reset values: state IDLE, LAST=host, FLOP_ACK=HOST_ACK=WP_HIT=0, RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, FLOP_RDATA=HOST_RDATA=0, DIRTY=00.
- Latency: REQ sampled high in IDLE at edge N → RAM driven during cycle N+1 → ACK high during cycle N+2.
- Throughput: one access per 3 cycles.
- A back-to-back contended pair completes the second ACK 3 cycles after the first.
- RAM_WE is high for exactly one cycle per unsuppressed write.
- RDATA changes only on the ACK edge of a read for that requester.
- Reset asserted mid-access:
  - RAM_WE and ACKs drop immediately (asynchronous).
  - The in-flight access is abandoned; DIRTY is not set.
  - Requesters must re-issue.
- FLOP_ADDR and FLOP_WE changing after grant have no effect on the access in flight.

## Test plan
- Floppy read only: RAM[0x00123]=0xD5, FLOP_REQ with addr 0x00123 at edge 0 → RAM_ADDR=0x00123 in cycle 1, FLOP_ACK and FLOP_RDATA=0xD5 in cycle 2, HOST_ACK stays 0.
- Contention: FLOP_REQ and HOST_REQ rise together from reset → floppy acked first (cycle 2), host acked in cycle 5; a repeated tie then favours the floppy again (fairness alternation), checked over 8 consecutive tie pairs.
- Write protect: WP=01, floppy write 0xAA to drive 1 at 0x00040 → FLOP_ACK and WP_HIT pulse, RAM_WE never high, DIRTY=00. Same write with WP=00 → RAM_WE one cycle, DIRTY=01.
- Dirty set/clear collision: floppy write to drive 2 whose DONE cycle coincides with DIRTY_CLR=10 → DIRTY[1]=1 afterwards. DIRTY_CLR=10 alone next cycle → DIRTY=00.
- Host write then floppy read: host writes 0x96 to 0x18A7 (HOST_ACK) → floppy read of 0x18A7 returns 0x96. DIRTY is unchanged by the host write.
- Reset mid-ACCESS: RESET_N low during cycle 1 of a floppy write → RAM_WE falls immediately, all outputs at reset values, no ACK. After release, a new request completes normally.
